// File: rtl/winocnn_pkg.sv
// Shared widths and line type for the Winograd CNN datapath.
// Optional feature: DATA_TILE_SER_OVERFLOW_CHK_EN (see data_tile_serializer).
package winocnn_pkg;

  localparam int DATA_W        = 512;
  localparam int ADDR_W        = 8;
  localparam int ROW_W         = 64;
  localparam int ROWS_PER_TILE = 8;
  localparam int IDX_W         = $clog2(ROWS_PER_TILE);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } mem_line_t;

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_t;

endpackage

// File: rtl/line_fifo_2w1r.sv
// Line FIFO with two write ports (port 1 takes precedence) and one read port.
// Pushes that find no free slot are dropped and flagged on drop.
module line_fifo_2w1r
  import winocnn_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_1_en,
  input  mem_line_t     wr_1_data,
  input  logic          wr_2_en,
  input  mem_line_t     wr_2_data,
  input  logic          rd_en,
  output mem_line_t     rd_data,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          drop
);

  localparam int AW = $clog2(DEPTH);

  mem_line_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] free_slots;
  logic          accept_1;
  logic          accept_2;
  logic          pop;

  // Admission looks only at the current count, so a same-cycle pop never frees a slot early.
  assign free_slots = CW'(DEPTH) - count;
  assign accept_1   = wr_1_en && (free_slots != '0);
  assign accept_2   = wr_2_en && (free_slots > CW'(accept_1));
  assign drop       = (wr_1_en && !accept_1) || (wr_2_en && !accept_2);
  assign empty      = (count == '0);
  assign pop        = rd_en && !empty;
  assign rd_data    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (accept_1) mem[wr_ptr] <= wr_1_data;
    if (accept_2) mem[wr_ptr + AW'(accept_1)] <= wr_2_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(accept_1) + AW'(accept_2);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(accept_1) + CW'(accept_2) - CW'(pop);
    end
  end

endmodule

// File: rtl/data_tile_serializer.sv
// Buffers 512-bit memory lines and streams each one out as eight 64-bit tile rows.
// Define DATA_TILE_SER_OVERFLOW_CHK_EN to get a sticky overflow_out on dropped lines.
module data_tile_serializer
  import winocnn_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int STALL_SLACK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_1_in,
  input  logic [DATA_W-1:0] data_2_in,
  input  logic [ADDR_W-1:0] addr_1_in,
  input  logic [ADDR_W-1:0] addr_2_in,
  input  logic              package_1_valid_in,
  input  logic              package_2_valid_in,
  output logic              stall_out,
  output logic [ROW_W-1:0]  row_out,
  output logic [IDX_W-1:0]  row_idx_out,
  output logic [ADDR_W-1:0] tile_addr_out,
  output logic              row_valid_out,
  input  logic              row_ready_in,
  output logic              tile_last_out,
  output logic              overflow_out
);

  localparam int CW = $clog2(DEPTH) + 1;

  mem_line_t         line_1;
  mem_line_t         line_2;
  mem_line_t         head_line;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              fifo_drop;
  logic [CW-1:0]     fifo_count;

  ser_state_t        state;
  logic [DATA_W-1:0] line_data;
  logic [IDX_W-1:0]  idx;
  logic              handshake;
  logic              last_row;

  assign line_1 = '{data: data_1_in, addr: addr_1_in};
  assign line_2 = '{data: data_2_in, addr: addr_2_in};

  line_fifo_2w1r #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_1_en   (package_1_valid_in),
    .wr_1_data (line_1),
    .wr_2_en   (package_2_valid_in),
    .wr_2_data (line_2),
    .rd_en     (fifo_pop),
    .rd_data   (head_line),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .drop      (fifo_drop)
  );

  assign handshake = (state == SEND) && row_ready_in;
  assign last_row  = (idx == IDX_W'(ROWS_PER_TILE - 1));
  // The head is consumed either on an idle load or on the final row handshake, giving back-to-back tiles.
  assign fifo_pop  = !fifo_empty && ((state == IDLE) || (handshake && last_row));

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      line_data     <= '0;
      idx           <= '0;
      tile_addr_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            line_data     <= head_line.data;
            tile_addr_out <= head_line.addr;
            idx           <= '0;
            state         <= SEND;
          end
        end
        SEND: begin
          if (handshake) begin
            if (!last_row) begin
              idx <= idx + 1'b1;
            end else if (!fifo_empty) begin
              line_data     <= head_line.data;
              tile_addr_out <= head_line.addr;
              idx           <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign row_valid_out = (state == SEND);
  assign row_idx_out   = idx;
  assign row_out       = line_data[ROW_W*idx +: ROW_W];
  assign tile_last_out = (state == SEND) && last_row;
  assign stall_out     = (CW'(DEPTH) - fifo_count) < CW'(STALL_SLACK);

`ifdef DATA_TILE_SER_OVERFLOW_CHK_EN
  logic overflow_q;

  always_ff @(posedge clk) begin
    if (reset)          overflow_q <= 1'b0;
    else if (fifo_drop) overflow_q <= 1'b1;
  end

  assign overflow_out = overflow_q;
`else
  logic unused_drop;

  assign unused_drop  = fifo_drop;
  assign overflow_out = 1'b0;
`endif

endmodule

// File: tb/tb_data_tile_serializer.sv
// Directed bench for data_tile_serializer: vector table plus hand-written multi-cycle sequences.
// Honours DATA_TILE_SER_OVERFLOW_CHK_EN when predicting overflow_out.
module tb_data_tile_serializer;
  import winocnn_pkg::*;

`ifdef DATA_TILE_SER_OVERFLOW_CHK_EN
  localparam bit OVF_EXP = 1'b1;
`else
  localparam bit OVF_EXP = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] data_1_in;
  logic [DATA_W-1:0] data_2_in;
  logic [ADDR_W-1:0] addr_1_in;
  logic [ADDR_W-1:0] addr_2_in;
  logic              package_1_valid_in;
  logic              package_2_valid_in;
  logic              stall_out;
  logic [ROW_W-1:0]  row_out;
  logic [IDX_W-1:0]  row_idx_out;
  logic [ADDR_W-1:0] tile_addr_out;
  logic              row_valid_out;
  logic              row_ready_in;
  logic              tile_last_out;
  logic              overflow_out;

  int errors = 0;
  int checks = 0;

  data_tile_serializer #(
    .DEPTH       (8),
    .STALL_SLACK (4)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .data_1_in          (data_1_in),
    .data_2_in          (data_2_in),
    .addr_1_in          (addr_1_in),
    .addr_2_in          (addr_2_in),
    .package_1_valid_in (package_1_valid_in),
    .package_2_valid_in (package_2_valid_in),
    .stall_out          (stall_out),
    .row_out            (row_out),
    .row_idx_out        (row_idx_out),
    .tile_addr_out      (tile_addr_out),
    .row_valid_out      (row_valid_out),
    .row_ready_in       (row_ready_in),
    .tile_last_out      (tile_last_out),
    .overflow_out       (overflow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic       v1;
    logic [7:0] a1;
    logic       v2;
    logic [7:0] a2;
    logic       rdy;
    logic       erv;
    logic [2:0] eidx;
    logic [7:0] eaddr;
    logic [7:0] eseed;
  } vec_t;

  vec_t vecs[$];

  // Byte i of a line is seed+i, so row r holds bytes seed+8r .. seed+8r+7, low byte first.
  function automatic logic [DATA_W-1:0] make_line(input logic [7:0] seed);
    logic [DATA_W-1:0] l;
    logic [7:0]        b;
    l = '0;
    for (int i = 0; i < 64; i++) begin
      b = seed + 8'(i);
      l[8*i +: 8] = b;
    end
    return l;
  endfunction

  function automatic logic [ROW_W-1:0] exp_row(input logic [7:0] seed, input int r);
    logic [ROW_W-1:0] v;
    logic [7:0]       b;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      b = seed + 8'(8*r + i);
      v[8*i +: 8] = b;
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v1, input logic [7:0] a1,
                               input logic v2, input logic [7:0] a2,
                               input logic rdy);
    package_1_valid_in = v1;
    addr_1_in          = a1;
    data_1_in          = make_line(a1);
    package_2_valid_in = v2;
    addr_2_in          = a2;
    data_2_in          = make_line(a2);
    row_ready_in       = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkRow(input string tag, input logic erv, input logic [2:0] eidx,
                          input logic [7:0] eaddr, input logic [7:0] eseed, input logic estall);
    checkOutput({tag, ".valid"}, 64'(row_valid_out), 64'(erv));
    checkOutput({tag, ".last"}, 64'(tile_last_out), 64'(erv && (eidx == 3'd7)));
    checkOutput({tag, ".stall"}, 64'(stall_out), 64'(estall));
    if (erv) begin
      checkOutput({tag, ".idx"}, 64'(row_idx_out), 64'(eidx));
      checkOutput({tag, ".addr"}, 64'(tile_addr_out), 64'(eaddr));
      checkOutput({tag, ".row"}, row_out, exp_row(eseed, int'(eidx)));
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".valid"}, 64'(row_valid_out), 64'd0);
    checkOutput({tag, ".last"}, 64'(tile_last_out), 64'd0);
    checkOutput({tag, ".row"}, row_out, 64'd0);
    checkOutput({tag, ".idx"}, 64'(row_idx_out), 64'd0);
    checkOutput({tag, ".addr"}, 64'(tile_addr_out), 64'd0);
    checkOutput({tag, ".ovf"}, 64'(overflow_out), 64'd0);
    checkOutput({tag, ".stall"}, 64'(stall_out), 64'd0);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic addVec(input logic v1, input logic [7:0] a1, input logic v2, input logic [7:0] a2,
                        input logic rdy, input logic erv, input logic [2:0] eidx, input logic [7:0] eaddr);
    vec_t v;
    v.v1 = v1; v.a1 = a1; v.v2 = v2; v.a2 = a2; v.rdy = rdy;
    v.erv = erv; v.eidx = eidx; v.eaddr = eaddr; v.eseed = eaddr;
    vecs.push_back(v);
  endtask

  // Drains tiles whose addresses run first..first+n-1 with ready high; lines use seed == addr.
  task automatic drainTiles(input string tag, input logic [7:0] first, input int n);
    logic [7:0] a;
    for (int t = 0; t < n; t++) begin
      a = first + 8'(t);
      for (int r = 0; r < 8; r++) begin
        checkRow($sformatf("%s.t%0d.r%0d", tag, t, r), 1'b1, 3'(r), a, a, stall_out);
        checkOutput($sformatf("%s.t%0d.r%0d.addr_ok", tag, t, r), 64'(tile_addr_out), 64'(a));
        tick();
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    checkResetState("reset");
    reset = 1'b0;

    // Single line, then a dual-valid pair, then a tile with ready held low at row 3.
    addVec(1, 8'h05, 0, 8'h00, 1, 0, 0, 8'h00);
    for (int r = 0; r < 8; r++) addVec(0, 8'h00, 0, 8'h00, 1, 1, 3'(r), 8'h05);
    addVec(0, 8'h00, 0, 8'h00, 1, 0, 0, 8'h00);
    addVec(1, 8'h40, 1, 8'h80, 1, 0, 0, 8'h00);
    for (int r = 0; r < 8; r++) addVec(0, 8'h00, 0, 8'h00, 1, 1, 3'(r), 8'h40);
    for (int r = 0; r < 8; r++) addVec(0, 8'h00, 0, 8'h00, 1, 1, 3'(r), 8'h80);
    addVec(0, 8'h00, 0, 8'h00, 1, 0, 0, 8'h00);
    addVec(1, 8'hC0, 0, 8'h00, 1, 0, 0, 8'h00);
    for (int r = 0; r < 4; r++) addVec(0, 8'h00, 0, 8'h00, 1, 1, 3'(r), 8'hC0);
    for (int k = 0; k < 3; k++) addVec(0, 8'h00, 0, 8'h00, 0, 1, 3'd3, 8'hC0);
    for (int r = 4; r < 8; r++) addVec(0, 8'h00, 0, 8'h00, 1, 1, 3'(r), 8'hC0);
    addVec(0, 8'h00, 0, 8'h00, 1, 0, 0, 8'h00);

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k].v1, vecs[k].a1, vecs[k].v2, vecs[k].a2, vecs[k].rdy);
      tick();
      checkRow($sformatf("vec%0d", k), vecs[k].erv, vecs[k].eidx, vecs[k].eaddr, vecs[k].eseed, 1'b0);
      checkOutput($sformatf("vec%0d.ovf", k), 64'(overflow_out), 64'd0);
    end

    // Fill with ready low: stall from count 5, drops once 8 lines are stored.
    doReset();
    applyStimulus(1, 8'hA0, 1, 8'hA1, 0); tick();
    checkRow("fill.c0", 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1, 8'hA2, 1, 8'hA3, 0); tick();
    checkRow("fill.c1", 1'b1, 3'd0, 8'hA0, 8'hA0, 1'b0);
    applyStimulus(1, 8'hA4, 1, 8'hA5, 0); tick();
    checkOutput("fill.c2.stall", 64'(stall_out), 64'd1);
    checkOutput("fill.c2.ovf", 64'(overflow_out), 64'd0);
    applyStimulus(1, 8'hA6, 1, 8'hA7, 0); tick();
    checkOutput("fill.c3.stall", 64'(stall_out), 64'd1);
    applyStimulus(1, 8'hA8, 1, 8'hA9, 0); tick();
    checkOutput("fill.c4.ovf", 64'(overflow_out), 64'(OVF_EXP));
    applyStimulus(1, 8'hAA, 1, 8'hAB, 0); tick();
    checkOutput("fill.c5.ovf", 64'(overflow_out), 64'(OVF_EXP));
    checkRow("fill.c5", 1'b1, 3'd0, 8'hA0, 8'hA0, 1'b1);
    applyStimulus(0, 8'h00, 0, 8'h00, 1);
    drainTiles("fill.drain", 8'hA0, 9);
    checkRow("fill.end", 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    checkOutput("fill.end.ovf", 64'(overflow_out), 64'(OVF_EXP));

    // Push and pop in the same cycle at count 7.
    doReset();
    checkOutput("pp.reset.ovf", 64'(overflow_out), 64'd0);
    applyStimulus(1, 8'hB0, 1, 8'hB1, 0); tick();
    applyStimulus(1, 8'hB2, 1, 8'hB3, 0); tick();
    applyStimulus(1, 8'hB4, 1, 8'hB5, 0); tick();
    applyStimulus(1, 8'hB6, 1, 8'hB7, 0); tick();
    checkRow("pp.full7", 1'b1, 3'd0, 8'hB0, 8'hB0, 1'b1);
    applyStimulus(0, 8'h00, 0, 8'h00, 1);
    for (int r = 0; r < 7; r++) tick();
    checkRow("pp.row7", 1'b1, 3'd7, 8'hB0, 8'hB0, 1'b1);
    applyStimulus(1, 8'hB8, 0, 8'h00, 1); tick();
    checkRow("pp.next", 1'b1, 3'd0, 8'hB1, 8'hB1, 1'b1);
    checkOutput("pp.next.ovf", 64'(overflow_out), 64'd0);
    applyStimulus(0, 8'h00, 0, 8'h00, 1);
    drainTiles("pp.drain", 8'hB1, 8);
    checkRow("pp.end", 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    checkOutput("pp.end.ovf", 64'(overflow_out), 64'd0);

    // Reset during row 4 with lines queued, inputs active during reset.
    doReset();
    applyStimulus(1, 8'hC0, 0, 8'h00, 1); tick();
    applyStimulus(1, 8'hC1, 1, 8'hC2, 1); tick();
    applyStimulus(1, 8'hC3, 0, 8'h00, 1); tick();
    applyStimulus(0, 8'h00, 0, 8'h00, 1); tick(); tick(); tick();
    checkRow("rst.row4", 1'b1, 3'd4, 8'hC0, 8'hC0, 1'b0);
    reset = 1'b1;
    applyStimulus(1, 8'hEE, 1, 8'hEF, 1); tick();
    checkResetState("rst.mid");
    reset = 1'b0;
    applyStimulus(1, 8'hD0, 0, 8'h00, 1); tick();
    checkRow("rst.after.c0", 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    applyStimulus(0, 8'h00, 0, 8'h00, 1); tick();
    drainTiles("rst.after", 8'hD0, 1);
    checkRow("rst.end", 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_tile_serializer.md
DATA_TILE_SERIALIZER -- requirements
Module: data_tile_serializer

Interface
REQ-001 Parameter DEPTH, default 8, line-FIFO entries (power of two, >=8).
REQ-002 Parameter STALL_SLACK, default 4, free entries below which stall_out asserts.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_1_in  input  512  port-1 read line from data memory.
REQ-006 data_2_in  input  512  port-2 read line from data memory.
REQ-007 addr_1_in / addr_2_in  input  8 each  line address accompanying each port.
REQ-008 package_1_valid_in / package_2_valid_in  input  1 each  line on that port is valid this cycle.
REQ-009 stall_out  output  1  to address controller: stop issuing reads.
REQ-010 row_out  output  64  one 8x8-bit tile row to Winograd input transform.
REQ-011 row_idx_out  output  3  row index 0..7 within current tile.
REQ-012 tile_addr_out  output  8  address of the line being serialized.
REQ-013 row_valid_out  output  1  row_out/row_idx_out/tile_addr_out valid.
REQ-014 row_ready_in  input  1  consumer accepts row when high with row_valid_out.
REQ-015 tile_last_out  output  1  high with row_valid_out when row_idx_out==7.
REQ-016 overflow_out  output  1  sticky: a valid line was dropped.

Function
REQ-017 FIFO SHALL store {data,addr} per entry; same-cycle dual valids enqueue port 1 before port 2.
REQ-018 Push and pop in the same cycle SHALL both take effect; count = count + pushes - pop.
REQ-019 A push when FIFO is full SHALL be dropped (port 1 accepted first if exactly one slot free).
REQ-020 stall_out SHALL be combinational: high when (DEPTH - count) < STALL_SLACK.
REQ-021 FSM states IDLE and SEND.
REQ-022 IDLE: if FIFO non-empty, load head line into row register, pop, row index 0, go SEND; else stay.
REQ-023 SEND: row_valid_out=1; row_out = line[64*idx +: 64] (row 0 = bits 63:0); outputs held stable while row_ready_in low.
REQ-024 SEND, handshake at idx<7: idx increments.
REQ-025 SEND, handshake at idx==7: if FIFO non-empty, load next head and pop same cycle (no bubble), idx=0, stay SEND; else go IDLE.
REQ-026 Latency: line valid at cycle t into empty FIFO and IDLE FSM SHALL produce row_valid_out at cycle t+2.
REQ-027 Lines SHALL emerge in enqueue order; wrap-around of FIFO pointers SHALL be transparent.

Reset
REQ-028 On reset: FIFO empty, FSM IDLE, idx 0, row_valid_out 0, tile_last_out 0, row_out 0, row_idx_out 0, tile_addr_out 0, overflow_out 0, stall_out 0.
REQ-029 Reset asserted mid-tile SHALL abort the tile and discard all FIFO contents; inputs during reset ignored.

Configuration
REQ-030 Macro DATA_TILE_SER_OVERFLOW_CHK_EN defined: overflow_out sets on any dropped push and holds until reset.
REQ-031 Macro undefined: overflow_out tied 0; drop behaviour of REQ-019 unchanged.

Structure
REQ-032 Package winocnn_pkg SHALL hold DATA_W=512, ADDR_W=8, ROW_W=64, ROWS_PER_TILE=8 and typedef mem_line_t {data, addr}.
REQ-033 FIFO SHALL be sub-module line_fifo_2w1r (two write ports, one read port, count output); FSM and row mux in top.

Verification
REQ-034 Single line addr 0x05 data 0x...0706050403020100 -> rows 0..7 at t+2..t+9 with ready=1, row 0 = 0x0706050403020100, tile_last on row 7, then IDLE.
REQ-035 Dual valid addrs 0x05/0x0A same cycle -> tile 0x05 fully before 0x0A, back-to-back, no idle cycle between row 7 and next row 0.
REQ-036 row_ready_in low 3 cycles at row 3 -> row_out/row_idx_out=3 held stable, then resume at 4.
REQ-037 Dual valids every cycle, ready=0 -> stall_out high when count>=5; after 8 stored, further pushes dropped, overflow_out=1 (macro on) / 0 (macro off).
REQ-038 Reset pulsed during row 4 with 3 lines queued -> next cycle all outputs at reset values, new line after reset serialized from row 0.
REQ-039 Push and pop same cycle at count 7 -> count stays 7, no drop, no overflow.
